chess_clock_timer: RTL and testbench
====================================

# chess_clock_timer

Per-player countdown timer for the chess clock. One instance per player sits beside the chess clock control FSM. It takes that player's stop level and the global restart level from the FSM, and returns the player's zero flag. It counts a minutes:seconds budget down in BCD while running, adds a Fischer increment at the end of each turn, and drives the display digits.

## Interface
- CLK_HZ, 100_000_000, clock cycles per second; ≥ 2
- INIT_MIN, 5, initial minutes; 0..99
- INIT_SEC, 0, initial seconds; 0..59
- INC_SEC, 0, increment seconds added at end of each turn; 0..59
- i_clk  in  1  single clock; all logic on posedge
- i_rst  in  1  reset, synchronous, active-high
- i_restart  in  1  level; reload initial time (from FSM restart output)
- i_stop  in  1  level; 1 = clock halted, 0 = this player's clock runs (from FSM player stop output)
- o_zero  out  1  time is 00:00; feeds FSM player zero input
- o_tick  out  1  one-cycle pulse, one cycle after each 1 s decrement
- o_min_t, o_min_u, o_sec_t, o_sec_u  out  4 each  BCD display digits, direct from time registers

## Operation
- State: prescaler cnt (0..CLK_HZ-1), BCD time {min_t, min_u, sec_t, sec_u}, stop_q (previous i_stop), tick register.
- Priority per cycle: i_rst > i_restart > increment > tick decrement.
- Reset and restart:
  - Time is loaded with INIT_MIN:INIT_SEC.
  - cnt is set to 0.
  - stop_q is set to 1, so leaving the restart never counts as a turn end.
  - o_tick is set to 0.
- Run (i_stop=0, not restart):
  - cnt increments each cycle.
  - At cnt==CLK_HZ-1, cnt wraps to 0. On that same edge the time decrements by 1 s if it is nonzero, and the tick register sets.
- Halt (i_stop=1): cnt is held, not cleared. The partial second resumes on the next turn.
- Decrement borrow chain:
  - sec_u 0→9 borrows from sec_t.
  - sec_t 0→5 borrows from min_u.
  - min_u 0→9 borrows from min_t.
  - At 00:00 there is no decrement and no wrap. The time stays at 00:00 until restart.
- Increment:
  - Fires on the rising edge of i_stop (i_stop=1 && stop_q=0) when the time is nonzero.
  - s = sec_t*10+sec_u+INC_SEC. If s≥60, seconds become s-60 and minutes increase by 1.
  - The result saturates at 99:59.
  - No increment when the time is 00:00 (game is lost).
- o_zero = (time == 00:00). It is combinational from registers and is sticky until restart or reset.
- Rising stop edge and tick never coincide: the tick requires i_stop=0 in the same cycle.

## Timing
- Reset values:
  - o_zero = (INIT_MIN==0 && INIT_SEC==0).
  - o_tick = 0.
  - Digits = INIT_MIN:INIT_SEC in BCD.
- First decrement lands on the CLK_HZ-th consecutive running edge after i_stop falls from a fresh restart.
- o_tick is high the cycle after the decrement edge, for exactly 1 cycle.
- o_zero rises on the same edge as the decrement to 00:00, i.e. 0 cycles after the digit change.
- Increment is applied on the edge where i_stop is sampled 1 after being 0. Digits update 1 cycle after the i_stop rise is presented.
- Restart mid-run: time reloads on the next edge. The partial second is discarded.

## Structure
- Shared package chess_clock_pkg holds:
  - typedef bcd_time_t as a packed struct of four 4-bit digits.
  - Constants TIME_ZERO (00:00) and TIME_MAX (99:59).
  - Function bcd_from_int(0..99) used for parameter loading.
- Sub-module chess_clock_prescaler:
  - Ports: i_clk, i_rst, i_clear, i_en, o_tick.
  - Behaviour: holds its count when i_en=0.
- Top-level timer instantiates the prescaler and holds the BCD datapath.

## Test plan
All scenarios use CLK_HZ=4, INIT 00:03, INC_SEC=2 unless noted.

- Reset then hold i_stop=1 for 20 cycles → digits stay 00:03, o_tick never pulses, o_zero=0.
- i_stop=0 continuously → decrements on running edges 4, 8, 12 to 00:02, 00:01, 00:00. o_zero rises with the 00:00 update. o_tick pulses 3×. Time stays 00:00 afterwards.
- Run 2 cycles, stop 5 cycles, run again → first decrement after 2 more running cycles (cnt held). Stop rise gives 00:05 (3+2 increment).
- INIT 99:58, run to 99:57, raise i_stop → saturates at 99:59. Separately, INIT 00:59 with a stop rise → 01:01.
- Reach 00:00, then toggle i_stop 0→1 → no increment, o_zero stays 1. Assert i_restart 1 cycle → 00:03, o_zero=0, no increment when i_stop stays 1.
- Assert i_restart mid-second (cnt=2) while running → reload 00:03. Next decrement is a full 4 running cycles later. Same behaviour for i_rst.

Source files
------------

// File: rtl/chess_clock_pkg.sv
// Shared types and helpers for the chess clock player timers.
// Time is held as four BCD digits so the display needs no conversion.
package chess_clock_pkg;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '{min_t: 4'd0, min_u: 4'd0, sec_t: 4'd0, sec_u: 4'd0};
    localparam bcd_time_t TIME_MAX  = '{min_t: 4'd9, min_u: 4'd9, sec_t: 4'd5, sec_u: 4'd9};

    // Returns {tens, units} for a value in 0..99.
    function automatic logic [7:0] bcd_from_int(input int unsigned value);
        return {4'(value / 32'd10), 4'(value % 32'd10)};
    endfunction

endpackage

// File: rtl/chess_clock_prescaler.sv
// One-second prescaler: counts enabled cycles and strobes on the last one.
// The count is held (not cleared) while disabled so a partial second survives a halt.
module chess_clock_prescaler
    import chess_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            cnt <= '0;
        end else if (i_en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Wrap strobe: high during the cycle whose edge wraps the count.
    assign o_tick = i_en && (cnt == CNT_LAST);

endmodule

// File: rtl/chess_clock_timer.sv
// Per-player countdown timer: BCD minutes:seconds, 1 s decrement while running,
// Fischer increment on each turn end, sticky zero flag for the control FSM.
module chess_clock_timer
    import chess_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned INIT_MIN = 5,
    parameter int unsigned INIT_SEC = 0,
    parameter int unsigned INC_SEC  = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_restart,
    input  logic       i_stop,
    output logic       o_zero,
    output logic       o_tick,
    output logic [3:0] o_min_t,
    output logic [3:0] o_min_u,
    output logic [3:0] o_sec_t,
    output logic [3:0] o_sec_u
);

    localparam logic [7:0] INIT_MIN_BCD = bcd_from_int(INIT_MIN);
    localparam logic [7:0] INIT_SEC_BCD = bcd_from_int(INIT_SEC);
    localparam bcd_time_t  INIT_TIME = '{
        min_t: INIT_MIN_BCD[7:4], min_u: INIT_MIN_BCD[3:0],
        sec_t: INIT_SEC_BCD[7:4], sec_u: INIT_SEC_BCD[3:0]
    };

    bcd_time_t  time_q;
    bcd_time_t  time_dec;
    bcd_time_t  time_inc;
    logic       stop_q;
    logic       tick_q;
    logic       sec_wrap;
    logic       time_zero;
    logic       stop_rise;
    logic       reload;
    logic [6:0] sec_sum;
    logic [6:0] sec_val;
    logic [6:0] min_sum;
    logic       sec_carry;

    assign reload = i_rst || i_restart;

    chess_clock_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_restart),
        .i_en    (!i_stop),
        .o_tick  (sec_wrap)
    );

    assign time_zero = (time_q == TIME_ZERO);
    assign stop_rise = i_stop && !stop_q;

    // Borrow chain; only consumed when the time is nonzero, so min_t never underflows.
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        time_dec = time_q;
        if (time_q.sec_u != 4'd0) begin
            time_dec.sec_u = time_q.sec_u - 4'd1;
        end else begin
            time_dec.sec_u = 4'd9;
            if (time_q.sec_t != 4'd0) begin
                time_dec.sec_t = time_q.sec_t - 4'd1;
            end else begin
                time_dec.sec_t = 4'd5;
                if (time_q.min_u != 4'd0) begin
                    time_dec.min_u = time_q.min_u - 4'd1;
                end else begin
                    time_dec.min_u = 4'd9;
                    time_dec.min_t = time_q.min_t - 4'd1;
                end
            end
        end
    end

    // Fischer increment in binary, converted back to BCD; clamps at 99:59.
    always_comb begin
        time_inc  = time_q;
        sec_sum   = 7'(time_q.sec_t) * 7'd10 + 7'(time_q.sec_u) + 7'(INC_SEC);
        sec_carry = (sec_sum >= 7'd60);
        sec_val   = sec_carry ? (sec_sum - 7'd60) : sec_sum;
        min_sum   = 7'(time_q.min_t) * 7'd10 + 7'(time_q.min_u) + 7'(sec_carry);
        if (min_sum > 7'd99) begin
            time_inc = TIME_MAX;
        end else begin
            {time_inc.min_t, time_inc.min_u} = bcd_from_int(32'(min_sum));
            {time_inc.sec_t, time_inc.sec_u} = bcd_from_int(32'(sec_val));
        end
    end

    // stop_q reloads to 1 so releasing a restart is never mistaken for a turn end.
    always_ff @(posedge i_clk) begin
        if (reload) begin
            time_q <= INIT_TIME;
            stop_q <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            stop_q <= i_stop;
            tick_q <= 1'b0;
            if (stop_rise && !time_zero) begin
                time_q <= time_inc;
            end else if (sec_wrap && !time_zero) begin
                time_q <= time_dec;
                tick_q <= 1'b1;
            end
        end
    end

    assign o_zero  = time_zero;
    assign o_tick  = tick_q;
    assign o_min_t = time_q.min_t;
    assign o_min_u = time_q.min_u;
    assign o_sec_t = time_q.sec_t;
    assign o_sec_u = time_q.sec_u;

endmodule

// File: tb/tb_chess_clock_timer.sv
// Directed bench for chess_clock_timer with CLK_HZ=4: main 00:03/+2 instance plus
// 99:58 and 00:59 instances for saturation and seconds carry.
module tb_chess_clock_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, restart_a = 1'b0, stop_a = 1'b1;
    logic rst_b = 1'b0, restart_b = 1'b0, stop_b = 1'b1;
    logic rst_c = 1'b0, restart_c = 1'b0, stop_c = 1'b1;

    logic       zero_a, tick_a, zero_b, tick_b, zero_c, tick_c;
    logic [3:0] a_mt, a_mu, a_st, a_su;
    logic [3:0] b_mt, b_mu, b_st, b_su;
    logic [3:0] c_mt, c_mu, c_st, c_su;
    logic [15:0] dig_a, dig_b, dig_c;

    assign dig_a = {a_mt, a_mu, a_st, a_su};
    assign dig_b = {b_mt, b_mu, b_st, b_su};
    assign dig_c = {c_mt, c_mu, c_st, c_su};

    chess_clock_timer #(.CLK_HZ(4), .INIT_MIN(0), .INIT_SEC(3), .INC_SEC(2)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_restart(restart_a), .i_stop(stop_a),
        .o_zero(zero_a), .o_tick(tick_a),
        .o_min_t(a_mt), .o_min_u(a_mu), .o_sec_t(a_st), .o_sec_u(a_su)
    );

    chess_clock_timer #(.CLK_HZ(4), .INIT_MIN(99), .INIT_SEC(58), .INC_SEC(2)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_restart(restart_b), .i_stop(stop_b),
        .o_zero(zero_b), .o_tick(tick_b),
        .o_min_t(b_mt), .o_min_u(b_mu), .o_sec_t(b_st), .o_sec_u(b_su)
    );

    chess_clock_timer #(.CLK_HZ(4), .INIT_MIN(0), .INIT_SEC(59), .INC_SEC(2)) dut_c (
        .i_clk(clk), .i_rst(rst_c), .i_restart(restart_c), .i_stop(stop_c),
        .o_zero(zero_c), .o_tick(tick_c),
        .o_min_t(c_mt), .o_min_u(c_mu), .o_sec_t(c_st), .o_sec_u(c_su)
    );

    int n_vec = 0;
    int n_bad = 0;
    int ticks;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        // Reset, then hold stopped: nothing moves.
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        cyc();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        check("rst_digits", dig_a, 16'h0003);
        check("rst_zero", 16'(zero_a), 16'h0);
        check("rst_tick", 16'(tick_a), 16'h0);
        check("rst_digits_b", dig_b, 16'h9958);
        check("rst_digits_c", dig_c, 16'h0059);
        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            ticks += int'(tick_a);
        end
        check("hold_digits", dig_a, 16'h0003);
        check("hold_ticks", 16'(ticks), 16'd0);
        check("hold_zero", 16'(zero_a), 16'h0);

        // Run continuously down to 00:00 and beyond.
        stop_a = 1'b0;
        ticks = 0;
        for (int k = 1; k <= 24; k++) begin
            cyc();
            ticks += int'(tick_a);
            if (k == 3)  check("run_pre1", dig_a, 16'h0003);
            if (k == 4)  check("run_dec1", dig_a, 16'h0002);
            if (k == 4)  check("run_tick_hi", 16'(tick_a), 16'h1);
            if (k == 5)  check("run_tick_lo", 16'(tick_a), 16'h0);
            if (k == 8)  check("run_dec2", dig_a, 16'h0001);
            if (k == 11) check("run_zero_pre", 16'(zero_a), 16'h0);
            if (k == 12) check("run_dec3", dig_a, 16'h0000);
            if (k == 12) check("run_zero_rise", 16'(zero_a), 16'h1);
        end
        check("run_ticks", 16'(ticks), 16'd3);
        check("run_stay_zero", dig_a, 16'h0000);

        // Turn end at 00:00 gives no increment.
        stop_a = 1'b1;
        cyc();
        check("lost_no_inc", dig_a, 16'h0000);
        check("lost_zero", 16'(zero_a), 16'h1);

        // Restart reloads; stop held high is not a turn end.
        restart_a = 1'b1;
        cyc();
        restart_a = 1'b0;
        check("restart_digits", dig_a, 16'h0003);
        check("restart_zero", 16'(zero_a), 16'h0);
        for (int k = 0; k < 3; k++) cyc();
        check("restart_no_inc", dig_a, 16'h0003);

        // Run 2, stop 5 (increment on rise, cnt held), run again.
        stop_a = 1'b0;
        cyc(); cyc();
        stop_a = 1'b1;
        cyc();
        check("inc_rise", dig_a, 16'h0005);
        for (int k = 0; k < 4; k++) cyc();
        check("inc_hold", dig_a, 16'h0005);
        stop_a = 1'b0;
        cyc();
        check("resume_pre", dig_a, 16'h0005);
        cyc();
        check("resume_dec", dig_a, 16'h0004);
        check("resume_tick", 16'(tick_a), 16'h1);

        // Restart mid-second discards the partial second.
        cyc(); cyc();
        restart_a = 1'b1;
        cyc();
        restart_a = 1'b0;
        check("mid_restart", dig_a, 16'h0003);
        cyc(); cyc(); cyc();
        check("mid_restart_pre", dig_a, 16'h0003);
        cyc();
        check("mid_restart_dec", dig_a, 16'h0002);

        // Same with synchronous reset.
        cyc(); cyc();
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        check("mid_rst", dig_a, 16'h0003);
        check("mid_rst_tick", 16'(tick_a), 16'h0);
        cyc(); cyc(); cyc();
        check("mid_rst_pre", dig_a, 16'h0003);
        cyc();
        check("mid_rst_dec", dig_a, 16'h0002);

        // Saturation at 99:59.
        stop_b = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        check("sat_run", dig_b, 16'h9957);
        stop_b = 1'b1;
        cyc();
        check("sat_inc", dig_b, 16'h9959);
        stop_b = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        check("sat_run2", dig_b, 16'h9958);
        stop_b = 1'b1;
        cyc();
        check("sat_clamp", dig_b, 16'h9959);

        // Seconds carry into minutes, then minute borrow back down.
        stop_c = 1'b0;
        cyc();
        stop_c = 1'b1;
        cyc();
        check("carry_inc", dig_c, 16'h0101);
        stop_c = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        check("borrow_1", dig_c, 16'h0100);
        for (int k = 0; k < 4; k++) cyc();
        check("borrow_min", dig_c, 16'h0059);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
